pwm_duty_sequencer: RTL



---
 rtl/pwm_duty_sequencer_pkg.sv | 17 +
 rtl/pwm_duty_sequencer_debounce.sv | 49 ++++
 rtl/pwm_duty_sequencer.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/pwm_duty_sequencer_pkg.sv
// Shared constants, state encoding and helpers for the PWM duty sequencer.
package pwm_pkg;

  localparam int DUTY_W     = 4;
  localparam int DUTY_MAX   = 10;
  localparam int DUTY_RESET = 5;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } seq_state_t;

  function automatic logic [DUTY_W-1:0] clamp_duty(input logic [DUTY_W-1:0] code);
    return (code > DUTY_W'(DUTY_MAX)) ? DUTY_W'(DUTY_MAX) : code;
  endfunction

endpackage

// File: rtl/pwm_duty_sequencer_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-count debounce and
// a single-cycle press pulse on the accepted 0->1 transition.
module btn_debounce
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC);

  logic             sync_p0;
  logic             sync_p1;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             flip;

  assign flip = (sync_p1 != level) && (cnt == CNT_W'(DEBOUNCE_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= flip && sync_p1;
      // Any cycle where the synced input agrees with the level restarts the count.
      if (sync_p1 != level) begin
        if (flip) begin
          level <= sync_p1;
          cnt   <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Duty-code sequencer for the PWM core: manual inc/dec or automatic ramp,
// with every change committed to the core only on a PWM period boundary.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16,
  parameter int RAMP_DIV     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_inc,
  input  logic              btn_dec,
  input  logic              ramp_en,
  input  logic [DUTY_W-1:0] ramp_target,
  input  logic              period_end,
  output logic [DUTY_W-1:0] duty_o,
  output logic              duty_load,
  output logic              busy,
  output logic              ramp_done,
  output logic              at_max,
  output logic              at_min
);

  localparam int                CNT_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DUTY_W-1:0] MAX_CODE = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] RST_CODE = DUTY_W'(DUTY_RESET);

  logic inc_press;
  logic dec_press;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_inc (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_inc),
    .press(inc_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_dec (
    .clk  (clk),
    .rst_n(rst_n),
    .btn  (btn_dec),
    .press(dec_press)
  );

  seq_state_t        state, state_nxt;
  logic [DUTY_W-1:0] duty_pend, pend_nxt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              load_nxt;
  logic              done_nxt;
  logic [CNT_W-1:0]  ramp_cnt, cnt_nxt;
  logic              done_hold, hold_nxt;
  logic [DUTY_W-1:0] done_tgt, htgt_nxt;
  logic [DUTY_W-1:0] tgt;

  assign tgt = clamp_duty(ramp_target);

  always_comb begin
    state_nxt = state;
    pend_nxt  = duty_pend;
    duty_nxt  = duty_o;
    load_nxt  = 1'b0;
    done_nxt  = 1'b0;
    cnt_nxt   = ramp_cnt;
    hold_nxt  = done_hold;
    htgt_nxt  = done_tgt;

    if (period_end && (duty_pend != duty_o)) begin
      duty_nxt = duty_pend;
      load_nxt = 1'b1;
    end

    unique case (state)
      IDLE: begin
        if (ramp_en) begin
          state_nxt = RAMP;
          cnt_nxt   = '0;
        end else begin
          hold_nxt = 1'b0;
          if (inc_press && !dec_press && (duty_pend != MAX_CODE))
            pend_nxt = duty_pend + 1'b1;
          else if (dec_press && !inc_press && (duty_pend != '0))
            pend_nxt = duty_pend - 1'b1;
        end
      end
      RAMP: begin
        // done_hold remembers a completed target so a held ramp_en idles quietly.
        if (done_hold && (tgt != done_tgt))
          hold_nxt = 1'b0;
        if (!ramp_en) begin
          state_nxt = IDLE;
        end else if ((duty_o == duty_pend) && (duty_pend == tgt) &&
                     !(done_hold && (done_tgt == tgt))) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          hold_nxt  = 1'b1;
          htgt_nxt  = tgt;
        end else if (period_end) begin
          if (ramp_cnt == CNT_W'(RAMP_DIV - 1)) begin
            cnt_nxt = '0;
            if (duty_pend < tgt)
              pend_nxt = duty_pend + 1'b1;
            else if (duty_pend > tgt)
              pend_nxt = duty_pend - 1'b1;
          end else begin
            cnt_nxt = ramp_cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      duty_pend <= RST_CODE;
      duty_o    <= RST_CODE;
      duty_load <= 1'b0;
      ramp_done <= 1'b0;
      ramp_cnt  <= '0;
      done_hold <= 1'b0;
      done_tgt  <= '0;
      busy      <= 1'b0;
      at_max    <= 1'b0;
      at_min    <= 1'b0;
    end else begin
      state     <= state_nxt;
      duty_pend <= pend_nxt;
      duty_o    <= duty_nxt;
      duty_load <= load_nxt;
      ramp_done <= done_nxt;
      ramp_cnt  <= cnt_nxt;
      done_hold <= hold_nxt;
      done_tgt  <= htgt_nxt;
      busy      <= (state_nxt != IDLE) || (pend_nxt != duty_nxt);
      at_max    <= (duty_nxt == MAX_CODE);
      at_min    <= (duty_nxt == '0);
    end
  end

endmodule
